// File: rtl/prog_loader.sv
// prog_loader
//   Boot-time loader for the 16-bit pipelined cpu. Consumes a valid/ready
//   stream of checksummed records and writes their payload into IMEM or DMEM
//   through a single write port. The cpu is held in reset until the
//   terminator record has been accepted.
//
//   Record: HEADER {sel, count[14:0]}, ADDR, count x DATA, CSUM
//           CSUM = (HEADER + ADDR + sum(DATA)) mod 2^16
//           A HEADER with count == 0 is the terminator (no ADDR/CSUM).
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   stream word valid
//   in_ready   loader can accept a word
//   in_data    stream word
//   mem_we     one-cycle write strobe
//   mem_sel    0 = IMEM, 1 = DMEM
//   mem_addr   write word address
//   mem_wdata  write data
//   cpu_reset  reset to cpu, high until loading is done
//   done       load complete (sticky until reset)
//   err        checksum error (sticky until reset)
module prog_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  mem_we,
    output logic                  mem_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  err
);

    localparam logic [2:0] S_HDR  = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]            state;
    logic                  sel;
    logic [14:0]           remaining;
    logic [DATA_WIDTH-1:0] sum;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  accept;

    // Running checksum is a plain modular add; overflow is discarded.
    function automatic logic [DATA_WIDTH-1:0] csum_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        return a + b;
    endfunction

    // Ready is forced low while reset is asserted, not just after the edge.
    assign in_ready = !reset && (state == S_HDR  || state == S_ADDR ||
                                 state == S_DATA || state == S_CSUM);
    assign accept    = in_valid && in_ready;

    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);
    assign cpu_reset = (state != S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_HDR;
            sel       <= 1'b0;
            remaining <= '0;
            sum       <= '0;
            addr      <= '0;
            mem_we    <= 1'b0;
            mem_sel   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_HDR: begin
                        if (in_data[14:0] == 15'd0) begin
                            state <= S_DONE;
                        end else begin
                            sel       <= in_data[DATA_WIDTH-1];
                            remaining <= in_data[14:0];
                            sum       <= in_data;
                            state     <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        addr  <= in_data[ADDR_WIDTH-1:0];
                        sum   <= csum_add(sum, in_data);
                        state <= S_DATA;
                    end
                    S_DATA: begin
                        // Write stage: strobe and payload appear the cycle after acceptance.
                        mem_we    <= 1'b1;
                        mem_sel   <= sel;
                        mem_addr  <= addr;
                        mem_wdata <= in_data;
                        addr      <= addr + ADDR_WIDTH'(1);
                        remaining <= remaining - 15'd1;
                        sum       <= csum_add(sum, in_data);
                        if (remaining == 15'd1) begin
                            state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        state <= (in_data == sum) ? S_HDR : S_ERR;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        mem_we;
    logic        mem_sel;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    prog_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every write seen on the port, tagged with the cycle it appeared in.
    logic [24:0] got[$];
    int          got_cyc[$];
    always @(negedge clk) begin
        if (mem_we) begin
            got.push_back({mem_sel, mem_addr, mem_wdata});
            got_cyc.push_back(cyc);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: parse the word stream record by record and list the writes
    // it must produce, how many words the loader takes, and the final status.
    task automatic model(input logic [15:0] ws[$], output logic [24:0] exp[$],
                         output int acc, output bit mdone, output bit merr);
        int          i;
        int          cnt;
        logic [15:0] s;
        logic [15:0] a;
        logic        sl;
        exp.delete();
        acc = ws.size();
        mdone = 0;
        merr = 0;
        i = 0;
        while (i < ws.size()) begin
            if (ws[i][14:0] == 15'd0) begin
                acc = i + 1;
                mdone = 1;
                return;
            end
            sl  = ws[i][15];
            cnt = int'(ws[i][14:0]);
            s   = ws[i];
            a   = ws[i+1];
            s   = s + a;
            for (int k = 0; k < cnt; k++) begin
                exp.push_back({sl, 8'(int'(a) + k), ws[i+2+k]});
                s = s + ws[i+2+k];
            end
            i = i + 2 + cnt;
            if (ws[i] !== s) begin
                acc = i + 1;
                merr = 1;
                return;
            end
            i++;
        end
    endtask

    task automatic send(input logic [15:0] w, input int gap, output bit ok);
        ok = 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 4; t++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst in_ready", in_ready, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_sel", mem_sel, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst cpu_reset", cpu_reset, 1);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        reset = 1'b0;
        #1;
        chk("post-rst in_ready", in_ready, 1);
        got.delete();
        got_cyc.delete();
    endtask

    // gap >= 0: fixed idle cycles before each word; gap < 0: random 0..2.
    task automatic run_stream(input logic [15:0] ws[$], input int gap, input string tag);
        logic [24:0] exp[$];
        int          acc;
        bit          mdone;
        bit          merr;
        bit          ok;
        model(ws, exp, acc, mdone, merr);
        for (int i = 0; i < ws.size(); i++) begin
            send(ws[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap, ok);
            chk($sformatf("%s accept[%0d]", tag, i), ok, (i < acc));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, " done"}, done, mdone);
        chk({tag, " err"}, err, merr);
        chk({tag, " cpu_reset"}, cpu_reset, !mdone);
        chk({tag, " in_ready"}, in_ready, !(mdone || merr));
        chk({tag, " nwrites"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s write[%0d]", tag, i), got[i], exp[i]);
    endtask

    typedef struct {
        logic [15:0] w [8];
        int          n;
        bit          e_done;
        bit          e_err;
        int          e_nw;
    } vec_t;

    initial begin
        vec_t        vecs [4];
        logic [15:0] ws[$];
        bit          ok;
        int          nrec;
        int          cnt;
        logic [15:0] s;
        logic [15:0] wd;

        vecs[0].w = '{16'h8003, 16'h0010, 16'h1111, 16'h2222, 16'h3333, 16'hE679, 16'h0000, 16'h0000};
        vecs[0].n = 7; vecs[0].e_done = 1; vecs[0].e_err = 0; vecs[0].e_nw = 3;
        vecs[1].w = '{16'h8003, 16'h0010, 16'h1111, 16'h2222, 16'h3333, 16'hE67A, 16'h0000, 16'h0000};
        vecs[1].n = 7; vecs[1].e_done = 0; vecs[1].e_err = 1; vecs[1].e_nw = 3;
        vecs[2].w = '{16'h0002, 16'h00FF, 16'hAAAA, 16'hBBBB, 16'h6766, 16'h0000, 16'h0000, 16'h0000};
        vecs[2].n = 6; vecs[2].e_done = 1; vecs[2].e_err = 0; vecs[2].e_nw = 2;
        vecs[3].w = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[3].n = 1; vecs[3].e_done = 1; vecs[3].e_err = 0; vecs[3].e_nw = 0;

        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            ws.delete();
            for (int j = 0; j < vecs[v].n; j++) ws.push_back(vecs[v].w[j]);
            run_stream(ws, 0, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d tbl done", v), done, vecs[v].e_done);
            chk($sformatf("vec%0d tbl err", v), err, vecs[v].e_err);
            chk($sformatf("vec%0d tbl nwrites", v), got.size(), vecs[v].e_nw);
            for (int i = 1; i < got_cyc.size(); i++)
                chk($sformatf("vec%0d back-to-back[%0d]", v, i), got_cyc[i] - got_cyc[i-1], 1);
        end

        // in_valid toggled 1-0-0-1 between words
        do_reset();
        ws.delete();
        for (int j = 0; j < 7; j++) ws.push_back(vecs[0].w[j]);
        run_stream(ws, 2, "gapped");

        // reset after the second DATA word abandons the record
        do_reset();
        send(16'h8003, 0, ok);
        send(16'h0010, 0, ok);
        send(16'h1111, 0, ok);
        send(16'h2222, 0, ok);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst nwrites", got.size(), 2);
        if (got.size() == 2) chk("midrst last write", got[1], {1'b1, 8'h11, 16'h2222});
        chk("midrst cpu_reset", cpu_reset, 1);
        chk("midrst done", done, 0);
        got.delete();
        got_cyc.delete();
        run_stream(ws, 0, "replay");

        // terminator first: done/cpu_reset change on the cycle after acceptance
        do_reset();
        chk("term pre cpu_reset", cpu_reset, 1);
        send(16'h0000, 0, ok);
        chk("term accepted", ok, 1);
        #1;
        chk("term done", done, 1);
        chk("term cpu_reset", cpu_reset, 0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("term nwrites", got.size(), 0);

        // random multi-record streams, some with corrupted checksums
        for (int r = 0; r < 30; r++) begin
            ws.delete();
            nrec = $urandom_range(1, 3);
            for (int k = 0; k < nrec; k++) begin
                cnt = $urandom_range(1, 4);
                wd  = {1'($urandom_range(0, 1)), 15'(cnt)};
                s   = wd;
                ws.push_back(wd);
                wd = 16'($urandom);
                s  = s + wd;
                ws.push_back(wd);
                for (int d = 0; d < cnt; d++) begin
                    wd = 16'($urandom);
                    s  = s + wd;
                    ws.push_back(wd);
                end
                if ($urandom_range(0, 3) == 0) s = s + 16'h0001;
                ws.push_back(s);
            end
            ws.push_back(16'h0000);
            do_reset();
            run_stream(ws, -1, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
